// File: rtl/uart_param_transceiver.sv
`default_nettype none
// ============================================================================
// Module      : uart_param_transceiver
// Description : Parameterised UART transmitter and receiver with optional
//               parity, 1/2 stop bits, internal loopback and error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_param_transceiver #(
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 transmit,
  input  logic [DATA_BITS-1:0] TxData,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done,
  input  logic                 rx,
  input  logic                 loopback,
  output logic [DATA_BITS-1:0] RxData,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err
);

  localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
  localparam int c_IDX_W = 4;

  localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_IDX_W-1:0] c_DATA_LAST = c_IDX_W'(DATA_BITS - 1);
  localparam logic [c_IDX_W-1:0] c_STOP_LAST = c_IDX_W'(STOP_BITS - 1);
  localparam logic               c_ODD       = (PARITY == 2);
  localparam logic               c_HAS_PAR   = (PARITY != 0);

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_START  = 3'd1;
  localparam logic [2:0] c_ST_DATA   = 3'd2;
  localparam logic [2:0] c_ST_PARITY = 3'd3;
  localparam logic [2:0] c_ST_STOP   = 3'd4;

  // --------------------------------------------------------------------------
  // Transmitter
  // --------------------------------------------------------------------------
  logic [2:0]           r_tx_state;
  logic [2:0]           w_tx_next;
  logic [c_CNT_W-1:0]   r_tx_cnt;
  logic [c_IDX_W-1:0]   r_tx_idx;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic                 r_tx_par;
  logic                 w_tx_bit_end;
  logic                 w_tx_last_stop;
  logic                 w_tx_load;

  assign w_tx_bit_end   = (r_tx_cnt == c_BIT_LAST);
  assign w_tx_last_stop = (r_tx_state == c_ST_STOP) && w_tx_bit_end && (r_tx_idx == c_STOP_LAST);
  // A request in the final stop cycle chains the next frame with no idle gap.
  assign w_tx_load      = transmit && ((r_tx_state == c_ST_IDLE) || w_tx_last_stop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_state <= c_ST_IDLE;
    end else begin
      r_tx_state <= w_tx_next;
    end
  end

  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      c_ST_IDLE:   if (transmit) w_tx_next = c_ST_START;
      c_ST_START:  if (w_tx_bit_end) w_tx_next = c_ST_DATA;
      c_ST_DATA:   if (w_tx_bit_end && (r_tx_idx == c_DATA_LAST))
                     w_tx_next = c_HAS_PAR ? c_ST_PARITY : c_ST_STOP;
      c_ST_PARITY: if (w_tx_bit_end) w_tx_next = c_ST_STOP;
      c_ST_STOP:   if (w_tx_last_stop) w_tx_next = transmit ? c_ST_START : c_ST_IDLE;
      default:     w_tx_next = c_ST_IDLE;
    endcase
  end

  always_comb begin
    tx      = 1'b1;
    tx_busy = (r_tx_state != c_ST_IDLE);
    tx_done = w_tx_last_stop;
    case (r_tx_state)
      c_ST_START:  tx = 1'b0;
      c_ST_DATA:   tx = r_tx_shift[0];
      c_ST_PARITY: tx = r_tx_par;
      default:     tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
    end else begin
      if ((r_tx_state == c_ST_IDLE) || w_tx_bit_end) begin
        r_tx_cnt <= '0;
      end else begin
        r_tx_cnt <= r_tx_cnt + 1'b1;
      end

      if (w_tx_next != r_tx_state) begin
        r_tx_idx <= '0;
      end else if (w_tx_bit_end) begin
        r_tx_idx <= r_tx_idx + 1'b1;
      end

      if (w_tx_load) begin
        r_tx_shift <= TxData;
        r_tx_par   <= (^TxData) ^ c_ODD;
      end else if ((r_tx_state == c_ST_DATA) && w_tx_bit_end) begin
        r_tx_shift <= r_tx_shift >> 1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Receiver
  // --------------------------------------------------------------------------
  logic                 w_rx_line;
  logic                 r_rx_meta;
  logic                 r_rx_sync;
  logic [2:0]           r_rx_state;
  logic [2:0]           w_rx_next;
  logic [c_CNT_W-1:0]   r_rx_cnt;
  logic [c_IDX_W-1:0]   r_rx_idx;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic                 r_rx_par;
  logic                 r_rx_wait;
  logic                 w_rx_bit_end;
  logic                 w_rx_half;
  logic                 w_rx_shift_en;
  logic                 w_rx_par_en;
  logic                 w_rx_sample_stop;

  assign w_rx_line    = loopback ? tx : rx;
  assign w_rx_bit_end = (r_rx_cnt == c_BIT_LAST);
  assign w_rx_half    = (r_rx_cnt == c_HALF_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= w_rx_line;
      r_rx_sync <= r_rx_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_state <= c_ST_IDLE;
    end else begin
      r_rx_state <= w_rx_next;
    end
  end

  // After a framing error the line must go high before a new start is trusted.
  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      c_ST_IDLE:   if (!r_rx_sync && !r_rx_wait) w_rx_next = c_ST_START;
      c_ST_START:  if (w_rx_half) w_rx_next = r_rx_sync ? c_ST_IDLE : c_ST_DATA;
      c_ST_DATA:   if (w_rx_bit_end && (r_rx_idx == c_DATA_LAST))
                     w_rx_next = c_HAS_PAR ? c_ST_PARITY : c_ST_STOP;
      c_ST_PARITY: if (w_rx_bit_end) w_rx_next = c_ST_STOP;
      c_ST_STOP:   if (w_rx_bit_end) w_rx_next = c_ST_IDLE;
      default:     w_rx_next = c_ST_IDLE;
    endcase
  end

  always_comb begin
    w_rx_shift_en    = 1'b0;
    w_rx_par_en      = 1'b0;
    w_rx_sample_stop = 1'b0;
    case (r_rx_state)
      c_ST_DATA:   w_rx_shift_en    = w_rx_bit_end;
      c_ST_PARITY: w_rx_par_en      = w_rx_bit_end;
      c_ST_STOP:   w_rx_sample_stop = w_rx_bit_end;
      default:     w_rx_shift_en    = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_cnt   <= '0;
      r_rx_idx   <= '0;
      r_rx_shift <= '0;
      r_rx_par   <= 1'b0;
      r_rx_wait  <= 1'b0;
      RxData     <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if ((r_rx_state == c_ST_IDLE) || w_rx_bit_end ||
          ((r_rx_state == c_ST_START) && w_rx_half)) begin
        r_rx_cnt <= '0;
      end else begin
        r_rx_cnt <= r_rx_cnt + 1'b1;
      end

      if (w_rx_next != r_rx_state) begin
        r_rx_idx <= '0;
      end else if (w_rx_bit_end) begin
        r_rx_idx <= r_rx_idx + 1'b1;
      end

      if (w_rx_shift_en) begin
        r_rx_shift <= {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
      end
      if (w_rx_par_en) begin
        r_rx_par <= r_rx_sync;
      end

      if (w_rx_sample_stop && !r_rx_sync) begin
        r_rx_wait <= 1'b1;
      end else if (r_rx_sync) begin
        r_rx_wait <= 1'b0;
      end

      rx_valid <= w_rx_sample_stop;
      if (w_rx_sample_stop) begin
        RxData     <= r_rx_shift;
        parity_err <= c_HAS_PAR && (r_rx_par != ((^r_rx_shift) ^ c_ODD));
        frame_err  <= !r_rx_sync;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_param_transceiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_param_transceiver
// Description : Self-checking bench; three DUTs (no/even/odd parity) checked
//               against a frame-level bit-list model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_param_transceiver;

  localparam int CPB = 16;
  localparam int NI  = 3;

  typedef bit bitq_t[$];

  logic       clk = 1'b0;
  logic       reset_n;
  logic       transmit  [NI];
  logic [7:0] TxData    [NI];
  logic       loopback  [NI];
  logic       rx        [NI];
  logic       tx        [NI];
  logic       tx_busy   [NI];
  logic       tx_done   [NI];
  logic [7:0] RxData    [NI];
  logic       rx_valid  [NI];
  logic       parity_err[NI];
  logic       frame_err [NI];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Instance g uses PARITY=g; instance 2 also sends two stop bits.
  for (genvar g = 0; g < NI; g++) begin : g_dut
    uart_param_transceiver #(
      .DATA_BITS   (8),
      .PARITY      (g),
      .STOP_BITS   ((g == 2) ? 2 : 1),
      .CLKS_PER_BIT(CPB)
    ) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .transmit  (transmit[g]),
      .TxData    (TxData[g]),
      .tx        (tx[g]),
      .tx_busy   (tx_busy[g]),
      .tx_done   (tx_done[g]),
      .rx        (rx[g]),
      .loopback  (loopback[g]),
      .RxData    (RxData[g]),
      .rx_valid  (rx_valid[g]),
      .parity_err(parity_err[g]),
      .frame_err (frame_err[g])
    );
  end

  function automatic int par_of(input int i);
    return i;
  endfunction

  function automatic int stops_of(input int i);
    return (i == 2) ? 2 : 1;
  endfunction

  // Line bits of one frame: start, data LSB first, optional parity, stop bits.
  function automatic bitq_t frame_bits(input int p, input logic [7:0] d, input bit par_flip,
                                       input int nstop, input bit stop_v);
    bitq_t q;
    int    ones;
    ones = 0;
    q.push_back(1'b0);
    for (int k = 0; k < 8; k++) begin
      q.push_back(d[k]);
      ones += int'(d[k]);
    end
    if (p == 1) q.push_back(((ones % 2) == 1) ^ par_flip);
    if (p == 2) q.push_back(((ones % 2) == 0) ^ par_flip);
    for (int k = 0; k < nstop; k++) q.push_back(stop_v);
    return q;
  endfunction

  task automatic run_tx(input string name, input int i, input logic [7:0] d0, input logic [7:0] d1,
                        input int nf, input bit lb);
    bitq_t      exp_q;
    bitq_t      f;
    int         flen;
    int         wlen;
    int         total;
    int         done_at[$];
    logic [7:0] got_d[$];
    logic       got_pe[$];
    logic       got_fe[$];
    logic [7:0] ed;
    f     = frame_bits(par_of(i), d0, 1'b0, stops_of(i), 1'b1);
    flen  = f.size() * CPB;
    exp_q = f;
    if (nf == 2) begin
      f     = frame_bits(par_of(i), d1, 1'b0, stops_of(i), 1'b1);
      exp_q = {exp_q, f};
    end
    wlen  = exp_q.size() * CPB;
    total = wlen + 2 * CPB;
    @(negedge clk);
    loopback[i] = lb;
    TxData[i]   = d0;
    transmit[i] = 1'b1;
    for (int c = 0; c < total; c++) begin
      bit eb;
      bit ebusy;
      @(negedge clk);
      eb    = (c < wlen) ? exp_q[c / CPB] : 1'b1;
      ebusy = (c < wlen);
      checks++;
      if (tx[i] !== eb) begin
        errors++;
        $display("FAIL %s tx cycle %0d: got %b want %b", name, c, tx[i], eb);
      end
      checks++;
      if (tx_busy[i] !== ebusy) begin
        errors++;
        $display("FAIL %s tx_busy cycle %0d: got %b want %b", name, c, tx_busy[i], ebusy);
      end
      if (tx_done[i] === 1'b1) done_at.push_back(c);
      if (rx_valid[i] === 1'b1) begin
        got_d.push_back(RxData[i]);
        got_pe.push_back(parity_err[i]);
        got_fe.push_back(frame_err[i]);
      end
      if (c == 0) begin
        if (nf == 2) begin
          TxData[i] = d1;
        end else begin
          transmit[i] = 1'b0;
          TxData[i]   = ~d0;
        end
      end
      if (nf == 1 && c == 3 * CPB) transmit[i] = 1'b1;
      if (nf == 1 && c == 3 * CPB + 1) transmit[i] = 1'b0;
      if (nf == 2 && c == flen) transmit[i] = 1'b0;
    end
    loopback[i] = 1'b0;
    checks++;
    if (done_at.size() !== nf) begin
      errors++;
      $display("FAIL %s tx_done pulses: got %0d want %0d", name, done_at.size(), nf);
    end else begin
      for (int k = 0; k < nf; k++) begin
        checks++;
        if (done_at[k] !== (k + 1) * flen - 1) begin
          errors++;
          $display("FAIL %s tx_done cycle: got %0d want %0d", name, done_at[k], (k + 1) * flen - 1);
        end
      end
    end
    checks++;
    if (got_d.size() !== (lb ? nf : 0)) begin
      errors++;
      $display("FAIL %s rx_valid pulses: got %0d want %0d", name, got_d.size(), lb ? nf : 0);
    end else begin
      for (int k = 0; k < got_d.size(); k++) begin
        ed = (k == 0) ? d0 : d1;
        checks++;
        if (got_d[k] !== ed) begin
          errors++;
          $display("FAIL %s RxData[%0d]: got %h want %h", name, k, got_d[k], ed);
        end
        checks++;
        if ({got_pe[k], got_fe[k]} !== 2'b00) begin
          errors++;
          $display("FAIL %s flags[%0d]: got pe=%b fe=%b want 0 0", name, k, got_pe[k], got_fe[k]);
        end
      end
    end
  endtask

  task automatic run_rx(input string name, input int i, input logic [7:0] d, input bit par_flip,
                        input bit stop_v, input int low_tail);
    bitq_t      f;
    int         flen;
    int         total;
    int         nv;
    logic [7:0] gd;
    logic       gpe;
    logic       gfe;
    bit         epe;
    f     = frame_bits(par_of(i), d, par_flip, 1, stop_v);
    flen  = f.size() * CPB;
    total = flen + low_tail + 3 * CPB;
    nv    = 0;
    gd    = '0;
    gpe   = 1'b0;
    gfe   = 1'b0;
    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      if (rx_valid[i] === 1'b1) begin
        nv++;
        gd  = RxData[i];
        gpe = parity_err[i];
        gfe = frame_err[i];
      end
      if (c < flen)                 rx[i] = f[c / CPB];
      else if (c < flen + low_tail) rx[i] = 1'b0;
      else                          rx[i] = 1'b1;
    end
    epe = (par_of(i) != 0) && par_flip;
    checks++;
    if (nv !== 1) begin
      errors++;
      $display("FAIL %s rx_valid pulses: got %0d want 1", name, nv);
    end else begin
      checks++;
      if (gd !== d) begin
        errors++;
        $display("FAIL %s RxData: got %h want %h", name, gd, d);
      end
      checks++;
      if (gpe !== epe) begin
        errors++;
        $display("FAIL %s parity_err: got %b want %b", name, gpe, epe);
      end
      checks++;
      if (gfe !== !stop_v) begin
        errors++;
        $display("FAIL %s frame_err: got %b want %b", name, gfe, !stop_v);
      end
    end
    checks++;
    if ({parity_err[i], frame_err[i]} !== {epe, !stop_v}) begin
      errors++;
      $display("FAIL %s held flags: got pe=%b fe=%b want %b %b", name, parity_err[i], frame_err[i],
               epe, !stop_v);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      transmit[i] = 1'b0;
      TxData[i]   = 8'h00;
      loopback[i] = 1'b0;
      rx[i]       = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if ({tx[i], tx_busy[i], tx_done[i]} !== 3'b100) begin
        errors++;
        $display("FAIL reset_tx[%0d]: got tx=%b busy=%b done=%b want 1 0 0", i, tx[i], tx_busy[i], tx_done[i]);
      end
      checks++;
      if (RxData[i] !== 8'h00) begin
        errors++;
        $display("FAIL reset_rxdata[%0d]: got %h want 00", i, RxData[i]);
      end
      checks++;
      if ({rx_valid[i], parity_err[i], frame_err[i]} !== 3'b000) begin
        errors++;
        $display("FAIL reset_rxflags[%0d]: got v=%b pe=%b fe=%b want 0 0 0", i, rx_valid[i],
                 parity_err[i], frame_err[i]);
      end
    end
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if ({tx[i], tx_busy[i]} !== 2'b10) begin
        errors++;
        $display("FAIL idle_after_reset[%0d]: got tx=%b busy=%b want 1 0", i, tx[i], tx_busy[i]);
      end
    end
  endtask

  task automatic test_tx_a5();
    run_tx("tx_a5", 0, 8'hA5, 8'h00, 1, 1'b0);
  endtask

  task automatic test_loopback_even();
    run_tx("loop_even_07", 1, 8'h07, 8'h00, 1, 1'b1);
  endtask

  task automatic test_odd_parity();
    run_rx("odd_par_err_07", 2, 8'h07, 1'b1, 1'b1, 0);
    run_rx("odd_par_ok_07", 2, 8'h07, 1'b0, 1'b1, 0);
  endtask

  task automatic test_random();
    int         i;
    logic [7:0] d;
    bit         flip;
    for (int n = 0; n < 8; n++) begin
      i = int'($urandom_range(2, 0));
      d = 8'($urandom);
      run_tx("rand_tx", i, d, 8'h00, 1, 1'($urandom));
    end
    for (int n = 0; n < 8; n++) begin
      i    = int'($urandom_range(2, 0));
      d    = 8'($urandom);
      flip = (i != 0) ? 1'($urandom) : 1'b0;
      run_rx("rand_rx", i, d, flip, 1'b1, 0);
    end
  endtask

  task automatic test_frame_err();
    run_rx("frame_err_3c", 0, 8'h3C, 1'b0, 1'b0, 12 * CPB);
    run_rx("frame_err_recover", 0, 8'h5A, 1'b0, 1'b1, 0);
  endtask

  task automatic test_glitch();
    int nv;
    nv = 0;
    for (int c = 0; c < 4 * CPB; c++) begin
      @(negedge clk);
      if (rx_valid[0] === 1'b1) nv++;
      rx[0] = (c < 4) ? 1'b0 : 1'b1;
    end
    checks++;
    if (nv !== 0) begin
      errors++;
      $display("FAIL glitch rx_valid pulses: got %0d want 0", nv);
    end
    run_rx("glitch_recover", 0, 8'hC3, 1'b0, 1'b1, 0);
  endtask

  task automatic test_back_to_back();
    run_tx("b2b_even", 1, 8'($urandom), 8'($urandom), 2, 1'b1);
    run_tx("b2b_odd_2stop", 2, 8'($urandom), 8'($urandom), 2, 1'b1);
  endtask

  task automatic test_reset_midframe();
    bitq_t f;
    int    nd;
    int    nv;
    int    nhi;
    nd  = 0;
    nv  = 0;
    nhi = 0;
    f   = frame_bits(0, 8'h00, 1'b0, 1, 1'b1);
    @(negedge clk);
    loopback[0] = 1'b0;
    TxData[0]   = 8'h00;
    transmit[0] = 1'b1;
    for (int c = 0; c < 3 * CPB + 4; c++) begin
      @(negedge clk);
      if (c == 0) transmit[0] = 1'b0;
      rx[0] = f[c / CPB];
    end
    checks++;
    if ({tx[0], tx_busy[0]} !== 2'b01) begin
      errors++;
      $display("FAIL midframe_pre: got tx=%b busy=%b want 0 1", tx[0], tx_busy[0]);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({tx[0], tx_busy[0], tx_done[0], rx_valid[0]} !== 4'b1000) begin
      errors++;
      $display("FAIL midframe_async: got tx=%b busy=%b done=%b valid=%b want 1 0 0 0", tx[0],
               tx_busy[0], tx_done[0], rx_valid[0]);
    end
    repeat (3) @(negedge clk);
    rx[0]   = 1'b1;
    reset_n = 1'b1;
    for (int c = 0; c < 12 * CPB; c++) begin
      @(negedge clk);
      if (tx_done[0] === 1'b1) nd++;
      if (rx_valid[0] === 1'b1) nv++;
      if (tx[0] !== 1'b1) nhi++;
    end
    checks++;
    if (nd !== 0) begin
      errors++;
      $display("FAIL midframe tx_done pulses: got %0d want 0", nd);
    end
    checks++;
    if (nv !== 0) begin
      errors++;
      $display("FAIL midframe rx_valid pulses: got %0d want 0", nv);
    end
    checks++;
    if (nhi !== 0) begin
      errors++;
      $display("FAIL midframe tx not idle: got %0d low cycles want 0", nhi);
    end
    checks++;
    if (RxData[0] !== 8'h00) begin
      errors++;
      $display("FAIL midframe RxData: got %h want 00", RxData[0]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_tx_a5();
    test_loopback_even();
    test_odd_parity();
    test_random();
    test_frame_err();
    test_glitch();
    test_back_to_back();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
